bist_response_analyzer: RTL and testbench

- Output response analyzer for the memory BIST path. It sits at the memory read-data output, opposite the address/data stimulus side.
- Accepts each issued read (address, expected data, last marker) from the BIST controller and aligns it to memory read latency.
- Compares the aligned memory read data with the expected data.
- Reports a sticky pass/fail result, a saturating mismatch count, first-failure address and syndrome, and session completion.

---
 rtl/bist_response_analyzer_pkg.sv | 27 ++
 rtl/bist_response_analyzer_delay_line.sv | 39 +++
 rtl/bist_response_analyzer.sv | 181 ++++++++++++++++++
 tb/tb_bist_response_analyzer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_response_analyzer_pkg.sv
// Shared types and constants for the memory BIST response analyzer.
// Provides the session state encoding, MISR polynomial and read-latency bounds.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] MISR_POLY  = 8'h1D;
    localparam int         RD_LAT_MIN = 1;
    localparam int         RD_LAT_MAX = 4;

    // Out-of-range latencies are pulled to the nearest supported depth.
    function automatic int clamp_rd_lat(input int lat);
        if (lat < RD_LAT_MIN) begin
            clamp_rd_lat = RD_LAT_MIN;
        end else if (lat > RD_LAT_MAX) begin
            clamp_rd_lat = RD_LAT_MAX;
        end else begin
            clamp_rd_lat = lat;
        end
    endfunction

endpackage

// File: rtl/bist_response_analyzer_delay_line.sv
// Fixed-depth shift register with a valid bit per stage and a synchronous flush.
// Aligns issued-read descriptors with the memory read latency.
module bist_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    // Shift descriptors one stage per cycle; flush drops every in-flight entry.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/bist_response_analyzer.sv
// Memory BIST output response analyzer: latency-aligned compare, sticky fail,
// saturating mismatch count and first-failure capture. BIST_MISR_EN adds a signature MISR.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int A_WIDTH   = 4,
    parameter int D_WIDTH   = 8,
    parameter int RD_LAT    = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 rd_en,
    input  logic [A_WIDTH-1:0]   rd_addr,
    input  logic [D_WIDTH-1:0]   exp_data,
    input  logic                 rd_last,
    input  logic [D_WIDTH-1:0]   mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CNT_WIDTH-1:0] fail_count,
    output logic [A_WIDTH-1:0]   first_fail_addr,
    output logic [D_WIDTH-1:0]   first_fail_syn
`ifdef BIST_MISR_EN
    ,
    output logic [D_WIDTH-1:0]   signature
`endif
);

    localparam int LAT = clamp_rd_lat(RD_LAT);
    localparam int LW  = A_WIDTH + D_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_fail;
    logic [CNT_WIDTH-1:0] r_fail_count;
    logic [A_WIDTH-1:0]   r_first_addr;
    logic [D_WIDTH-1:0]   r_first_syn;

    logic                 w_cap;
    logic [LW-1:0]        w_in;
    logic                 w_out_valid;
    logic [LW-1:0]        w_out;
    logic                 w_out_last;
    logic [A_WIDTH-1:0]   w_out_addr;
    logic [D_WIDTH-1:0]   w_out_exp;
    logic                 w_cmp;
    logic                 w_mis;
    logic [D_WIDTH-1:0]   w_syn;

    // A start in the same cycle discards both the incoming read and the compare.
    assign w_cap = rd_en && (r_state == RUN) && !start;
    assign w_in  = {rd_last, rd_addr, exp_data};

    bist_delay_line #(
        .DEPTH (LAT),
        .WIDTH (LW)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .i_flush (start),
        .i_valid (w_cap),
        .i_data  (w_in),
        .o_valid (w_out_valid),
        .o_data  (w_out)
    );

    assign w_out_last = w_out[LW-1];
    assign w_out_addr = w_out[LW-2 -: A_WIDTH];
    assign w_out_exp  = w_out[D_WIDTH-1:0];
    assign w_cmp      = w_out_valid && !start;
    assign w_syn      = mem_rdata ^ w_out_exp;
    assign w_mis      = w_cmp && (w_syn != {D_WIDTH{1'b0}});

    // Session FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_count <= '0;
            r_first_addr <= '0;
            r_first_syn  <= '0;
        end else if (start) begin
            r_state      <= RUN;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_count <= '0;
            r_first_addr <= '0;
            r_first_syn  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                RUN: begin
                    if (rd_en && rd_last) begin
                        r_state <= DRAIN;
                    end else begin
                        r_state <= RUN;
                    end
                end
                DRAIN: begin
                    if (w_cmp && w_out_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase

            if (w_mis) begin
                r_fail <= 1'b1;
                if (r_fail_count != CNT_MAX) begin
                    r_fail_count <= r_fail_count + CNT_WIDTH'(1);
                end else begin
                    r_fail_count <= r_fail_count;
                end
                // First failure is latched once; later mismatches only count.
                if (!r_fail) begin
                    r_first_addr <= w_out_addr;
                    r_first_syn  <= w_syn;
                end else begin
                    r_first_addr <= r_first_addr;
                    r_first_syn  <= r_first_syn;
                end
            end else begin
                r_fail <= r_fail;
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign fail            = r_fail;
    assign fail_count      = r_fail_count;
    assign first_fail_addr = r_first_addr;
    assign first_fail_syn  = r_first_syn;

`ifdef BIST_MISR_EN
    localparam logic [D_WIDTH-1:0] W_POLY = D_WIDTH'(MISR_POLY);

    logic [D_WIDTH-1:0] r_sig;

    function automatic logic [D_WIDTH-1:0] misr_next(
        input logic [D_WIDTH-1:0] sig,
        input logic [D_WIDTH-1:0] din
    );
        misr_next = ({sig[D_WIDTH-2:0], 1'b0} ^ (sig[D_WIDTH-1] ? W_POLY : {D_WIDTH{1'b0}})) ^ din;
    endfunction

    // Signature folds in read data of every compare while a session is active.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_sig <= '0;
        end else if (w_cmp && ((r_state == RUN) || (r_state == DRAIN))) begin
            r_sig <= misr_next(r_sig, mem_rdata);
        end else begin
            r_sig <= r_sig;
        end
    end

    assign signature = r_sig;
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Scoreboard bench: two analyzers (latency 1 / 8-bit count, latency 3 / 4-bit count)
// share stimulus; session results from a list-based model are checked when done rises.
module tb_bist_response_analyzer;

    logic       clk = 1'b0;
    logic       reset, start, rd_en, rd_last;
    logic [3:0] rd_addr;
    logic [7:0] exp_data, rdata_in;
    logic [7:0] p0;
    logic [7:0] p1 [3];
    logic [7:0] mem0, mem1;
    int         cyc = 0;

    logic       busy0, done0, fail0, busy1, done1, fail1;
    logic [7:0] cnt0, ffs0, ffs1;
    logic [3:0] cnt1, ffa0, ffa1;
`ifdef BIST_MISR_EN
    logic [7:0] sig0, sig1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int fail; int cnt0; int cnt1; int addr; int syn; int cyc0; int cyc1; int sig;
    } res_t;
    res_t q0[$];
    res_t q1[$];
    res_t m0, m1;

    int sa [32];
    int se [32];
    int sd [32];
    int gap[32];

    always #5 clk = ~clk;

    // Memory model: returned data for a read appears 1 or 3 cycles after it is issued.
    always @(posedge clk) begin
        p0    <= rdata_in;
        p1[0] <= rdata_in;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        cyc   <= cyc + 1;
    end
    assign mem0 = p0;
    assign mem1 = p1[2];

    bist_response_analyzer #(.A_WIDTH(4), .D_WIDTH(8), .RD_LAT(1), .CNT_WIDTH(8)) dut0 (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .exp_data(exp_data), .rd_last(rd_last), .mem_rdata(mem0), .busy(busy0), .done(done0),
        .fail(fail0), .fail_count(cnt0), .first_fail_addr(ffa0), .first_fail_syn(ffs0)
`ifdef BIST_MISR_EN
        , .signature(sig0)
`endif
    );

    bist_response_analyzer #(.A_WIDTH(4), .D_WIDTH(8), .RD_LAT(3), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .exp_data(exp_data), .rd_last(rd_last), .mem_rdata(mem1), .busy(busy1), .done(done1),
        .fail(fail1), .fail_count(cnt1), .first_fail_addr(ffa1), .first_fail_syn(ffs1)
`ifdef BIST_MISR_EN
        , .signature(sig1)
`endif
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each rising done is matched against the oldest expected session result.
    logic done0_d = 1'b0;
    logic done1_d = 1'b0;
    always @(negedge clk) begin
        if (done0 && !done0_d) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_done", 1, 0);
            end else begin
                m0 = q0.pop_front();
                chk("dut0_fail", int'(fail0), m0.fail);
                chk("dut0_count", int'(cnt0), m0.cnt0);
                chk("dut0_first_addr", int'(ffa0), m0.addr);
                chk("dut0_first_syn", int'(ffs0), m0.syn);
                chk("dut0_done_cycle", cyc, m0.cyc0);
`ifdef BIST_MISR_EN
                chk("dut0_signature", int'(sig0), m0.sig);
`endif
            end
        end
        if (done1 && !done1_d) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 1, 0);
            end else begin
                m1 = q1.pop_front();
                chk("dut1_fail", int'(fail1), m1.fail);
                chk("dut1_count", int'(cnt1), m1.cnt1);
                chk("dut1_first_addr", int'(ffa1), m1.addr);
                chk("dut1_first_syn", int'(ffs1), m1.syn);
                chk("dut1_done_cycle", cyc, m1.cyc1);
`ifdef BIST_MISR_EN
                chk("dut1_signature", int'(sig1), m1.sig);
`endif
            end
        end
        done0_d = done0;
        done1_d = done1;
    end

    // Reference: whole-session result computed from the list of reads.
    task automatic push_expected(input int n, input int last_cyc);
        res_t r;
        int   mism = 0;
        int   first = -1;
        int   s = 0;
        for (int i = 0; i < n; i++) begin
            if (se[i] != sd[i]) begin
                mism++;
                if (first < 0) first = i;
            end
            s = ((s * 2) % 256) ^ ((s >= 128) ? 29 : 0) ^ sd[i];
        end
        r.fail = (mism > 0) ? 1 : 0;
        r.cnt0 = (mism > 255) ? 255 : mism;
        r.cnt1 = (mism > 15) ? 15 : mism;
        r.addr = (first >= 0) ? sa[first] : 0;
        r.syn  = (first >= 0) ? (se[first] ^ sd[first]) : 0;
        r.cyc0 = last_cyc + 1 + 1;
        r.cyc1 = last_cyc + 3 + 1;
        r.sig  = s;
        q0.push_back(r);
        q1.push_back(r);
    endtask

    task automatic session(input int n);
        int last_cyc = 0;
        int k = 0;
        start = 1'b1; rd_en = 1'b0; rd_last = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                rd_en = 1'b0; rdata_in = 8'($urandom);
                tick();
            end
            rd_en = 1'b1; rd_addr = 4'(sa[i]); exp_data = 8'(se[i]); rdata_in = 8'(sd[i]);
            rd_last = (i == n - 1);
            if (i == n - 1) last_cyc = cyc;
            tick();
        end
        rd_en = 1'b0; rd_last = 1'b0; rdata_in = 8'($urandom);
        push_expected(n, last_cyc);
        while (!(done0 && done1) && k < 20) begin
            tick();
            k++;
        end
        if (!(done0 && done1)) chk("session_done_timeout", 0, 1);
        tick();
    endtask

    task automatic check_cleared(input string tag, input int exp_busy);
        chk({tag, "_busy0"}, int'(busy0), exp_busy);
        chk({tag, "_busy1"}, int'(busy1), exp_busy);
        chk({tag, "_done0"}, int'(done0), 0);
        chk({tag, "_done1"}, int'(done1), 0);
        chk({tag, "_fail0"}, int'(fail0), 0);
        chk({tag, "_fail1"}, int'(fail1), 0);
        chk({tag, "_cnt0"}, int'(cnt0), 0);
        chk({tag, "_cnt1"}, int'(cnt1), 0);
        chk({tag, "_addr"}, int'(ffa0) + int'(ffa1), 0);
        chk({tag, "_syn"}, int'(ffs0) + int'(ffs1), 0);
    endtask

    task automatic fill_linear(input int n);
        for (int i = 0; i < n; i++) begin
            sa[i] = i % 16; se[i] = i % 16; sd[i] = i % 16; gap[i] = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; rd_en = 1'b0; rd_last = 1'b0;
        rd_addr = 4'd0; exp_data = 8'd0; rdata_in = 8'd0;
        tick(); tick();
        reset = 1'b0;
        check_cleared("reset", 0);

        // All pass, 16 reads.
        fill_linear(16);
        session(16);

        // Two faults: addr 5 returns 0F, addr 9 returns FF.
        fill_linear(16);
        sd[5] = 8'h0F; sd[9] = 8'hFF;
        session(16);

        // Saturation: 20 consecutive mismatches.
        fill_linear(20);
        for (int i = 0; i < 20; i++) begin
            sa[i] = (i + 3) % 16; sd[i] = se[i] ^ 8'hA5;
        end
        session(20);

        // Latency alignment: only the second read mismatches.
        fill_linear(4);
        sd[1] = 8'h33;
        session(4);

        // Single read ending the session immediately.
        fill_linear(1);
        sd[0] = 8'h80;
        session(1);

        // Signature sequence 01 then 80.
        fill_linear(2);
        se[0] = 8'h01; sd[0] = 8'h01; se[1] = 8'h80; sd[1] = 8'h80;
        session(2);

        // Restart during DRAIN after mismatches were recorded.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i); exp_data = 8'(i); rdata_in = ~8'(i);
            rd_last = (i == 5);
            tick();
        end
        rd_en = 1'b0; rd_last = 1'b0;
        chk("restart_pre_fail1", int'(fail1), 1);
        chk("restart_pre_busy0", int'(busy0), 1);
        start = 1'b1; tick(); start = 1'b0;
        check_cleared("restart", 1);
        repeat (6) tick();
        chk("restart_no_done0", int'(done0), 0);
        chk("restart_no_done1", int'(done1), 0);

        // Reset in the middle of a run.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i); exp_data = 8'(i); rdata_in = 8'(i) ^ 8'h55;
            tick();
        end
        rd_en = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared("midreset", 0);

        // Reads while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i); exp_data = 8'(i); rdata_in = 8'hEE;
            rd_last = (i == 2);
            tick();
        end
        rd_en = 1'b0; rd_last = 1'b0;
        repeat (6) tick();
        check_cleared("idle_reads", 0);

        // Randomized sessions with sparse faults and occasional gaps.
        for (int s = 0; s < 8; s++) begin
            int n;
            n = int'($urandom_range(1, 24));
            for (int i = 0; i < n; i++) begin
                sa[i]  = int'($urandom_range(0, 15));
                se[i]  = int'($urandom_range(0, 255));
                sd[i]  = ($urandom_range(0, 3) == 0) ? (se[i] ^ int'($urandom_range(1, 255))) : se[i];
                gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            session(n);
        end

        repeat (4) tick();
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
